// File: rtl/ip_mux_arb_pkg.sv
// Shared types and picker function for the ip_mux frame arbiter.
// Supports up to PICK_MAX requesters.
package ip_mux_arb_pkg;

  localparam int PICK_MAX = 32;
  localparam int PICK_IW  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  typedef struct packed {
    logic               found;
    logic [PICK_IW-1:0] idx;
  } pick_t;

  // First set bit after ptr, walking up (lsb_high) or down, with wrap.
  function automatic pick_t rr_select(
    input logic [PICK_MAX-1:0] req,
    input int unsigned         ptr,
    input int unsigned         n,
    input logic                lsb_high
  );
    pick_t       r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 1; k <= PICK_MAX; k++) begin
      if (k <= n && !r.found) begin
        idx = lsb_high ? (ptr + k) % n
                       : (ptr + n - k) % n;
        if (|(req & (PICK_MAX'(1) << idx))) begin
          r.found = 1'b1;
          r.idx   = PICK_IW'(idx);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ip_mux_arb_pick.sv
// Combinational round-robin / fixed-priority picker.
// Fixed mode searches from a constant virtual pointer.
module arb_rr_pick
  import ip_mux_arb_pkg::*;
#(
  parameter int N           = 4,
  parameter int IW          = 2,
  parameter int ROUND_ROBIN = 1,
  parameter int LSB_HIGH    = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_ptr;
  pick_t         w_pick;

  assign w_ptr = (ROUND_ROBIN != 0) ? i_ptr :
                 (LSB_HIGH != 0)    ? IW'(N - 1) : '0;

  assign w_pick = rr_select(PICK_MAX'(i_req), 32'(w_ptr),
                            N, (LSB_HIGH != 0));

  assign o_found = w_pick.found;
  assign o_idx   = IW'(w_pick.idx);

endmodule

// File: rtl/ip_mux_arb.sv
// Frame arbiter driving ip_mux enable/select.
// Select is held from grant until the last payload beat.
module ip_mux_arb
  import ip_mux_arb_pkg::*;
#(
  parameter int S_COUNT               = 4,
  parameter int SELECT_WIDTH          = $clog2(S_COUNT),
  parameter int ARB_TYPE_ROUND_ROBIN  = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [S_COUNT-1:0]      s_ip_hdr_valid,
  input  logic [S_COUNT-1:0]      req_mask,
  input  logic                    m_ip_hdr_valid,
  input  logic                    m_ip_hdr_ready,
  input  logic                    m_ip_payload_axis_tvalid,
  input  logic                    m_ip_payload_axis_tready,
  input  logic                    m_ip_payload_axis_tlast,
  output logic                    enable,
  output logic [SELECT_WIDTH-1:0] select,
  output logic [S_COUNT-1:0]      grant,
  output logic                    busy,
  output logic                    frame_done
);

  state_t                  r_state;
  state_t                  w_next;
  logic [SELECT_WIDTH-1:0] r_ptr;
  logic [SELECT_WIDTH-1:0] r_select;
  logic [S_COUNT-1:0]      r_grant;
  logic                    r_enable;
  logic                    r_busy;

  logic                    w_hdr_hs;
  logic                    w_last_hs;
  logic [S_COUNT-1:0]      w_elig;
  logic                    w_found;
  logic [SELECT_WIDTH-1:0] w_win;
  logic                    w_req_drop;
  logic                    w_start;

  assign w_hdr_hs  = m_ip_hdr_valid & m_ip_hdr_ready;
  assign w_last_hs = m_ip_payload_axis_tvalid
                   & m_ip_payload_axis_tready
                   & m_ip_payload_axis_tlast;
  assign w_elig     = s_ip_hdr_valid & ~req_mask;
  assign w_req_drop = ~w_elig[r_select];
  assign w_start    = (r_state == ST_IDLE) & w_found;

  arb_rr_pick #(
    .N           (S_COUNT),
    .IW          (SELECT_WIDTH),
    .ROUND_ROBIN (ARB_TYPE_ROUND_ROBIN),
    .LSB_HIGH    (ARB_LSB_HIGH_PRIORITY)
  ) u_pick (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: header handshake commits, request drop aborts.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) w_next = ST_HDR;
      end
      ST_HDR: begin
        if (w_hdr_hs)
          w_next = w_last_hs ? ST_IDLE : ST_PAYLOAD;
        else if (w_req_drop)
          w_next = ST_IDLE;
      end
      ST_PAYLOAD: begin
        if (w_last_hs) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Output registers: load on grant, clear on return to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_select <= '0;
      r_grant  <= '0;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
    end else if (w_start) begin
      r_select <= w_win;
      r_grant  <= S_COUNT'(1) << w_win;
      r_enable <= 1'b1;
      r_busy   <= 1'b1;
    end else if (r_state != ST_IDLE && w_next == ST_IDLE) begin
      r_grant  <= '0;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
    end
  end

  // Round-robin pointer advances only once the header is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= SELECT_WIDTH'(S_COUNT - 1);
    else if (r_state == ST_HDR && w_hdr_hs)
      r_ptr <= r_select;
  end

  assign enable     = r_enable;
  assign select     = r_select;
  assign grant      = r_grant;
  assign busy       = r_busy;
  assign frame_done = w_last_hs
                    & ((r_state == ST_PAYLOAD)
                    | ((r_state == ST_HDR) & w_hdr_hs));

endmodule
